// File: rtl/riscv_nn_wb_arbiter.sv
// Writeback arbiter: two buffered producers feed the register file's two write ports.
// Source 1 always lands last on a same-address collision; writes to R0 are dropped.
module riscv_nn_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  src0_valid_i,
  output logic                  src0_ready_o,
  input  logic [ADDR_WIDTH-1:0] src0_addr_i,
  input  logic [DATA_WIDTH-1:0] src0_data_i,
  input  logic                  src1_valid_i,
  output logic                  src1_ready_o,
  input  logic [ADDR_WIDTH-1:0] src1_addr_i,
  input  logic [DATA_WIDTH-1:0] src1_data_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  busy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Source FIFO storage
  logic [ADDR_WIDTH-1:0] addr0_q [DEPTH];
  logic [DATA_WIDTH-1:0] data0_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr1_q [DEPTH];
  logic [DATA_WIDTH-1:0] data1_q [DEPTH];

  logic [PtrW-1:0] wr_ptr0_q, wr_ptr0_d, rd_ptr0_q, rd_ptr0_d;
  logic [PtrW-1:0] wr_ptr1_q, wr_ptr1_d, rd_ptr1_q, rd_ptr1_d;
  logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic                  busy_q, busy_d;

  logic                  push0, push1, pop0, pop1;
  logic                  h0_vld, h1_vld, issue_a, issue_b, collide;
  logic [ADDR_WIDTH-1:0] h0_addr, h1_addr;
  logic [DATA_WIDTH-1:0] h0_data, h1_data;

  // Ready is based on fullness at the start of the cycle; no pop-bypass.
  assign src0_ready_o = rst_n && (cnt0_q != CntFull);
  assign src1_ready_o = rst_n && (cnt1_q != CntFull);

  assign push0 = src0_valid_i && src0_ready_o && !flush_i;
  assign push1 = src1_valid_i && src1_ready_o && !flush_i;

  assign h0_vld  = (cnt0_q != '0);
  assign h1_vld  = (cnt1_q != '0);
  assign h0_addr = addr0_q[rd_ptr0_q];
  assign h0_data = data0_q[rd_ptr0_q];
  assign h1_addr = addr1_q[rd_ptr1_q];
  assign h1_data = data1_q[rd_ptr1_q];

  always_comb begin
    issue_a = h0_vld && (h0_addr != '0);
    // Holding head 1 one cycle lets its value overwrite head 0's.
    collide = issue_a && h1_vld && (h1_addr == h0_addr);
    issue_b = h1_vld && !collide && (h1_addr != '0);
    pop0    = h0_vld && !flush_i;
    pop1    = h1_vld && !collide && !flush_i;
  end

  always_comb begin
    wr_ptr0_d = wr_ptr0_q;
    rd_ptr0_d = rd_ptr0_q;
    wr_ptr1_d = wr_ptr1_q;
    rd_ptr1_d = rd_ptr1_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (flush_i) begin
      wr_ptr0_d = '0;
      rd_ptr0_d = '0;
      wr_ptr1_d = '0;
      rd_ptr1_d = '0;
      cnt0_d    = '0;
      cnt1_d    = '0;
    end else begin
      if (push0) wr_ptr0_d = wr_ptr0_q + PtrW'(1);
      if (pop0)  rd_ptr0_d = rd_ptr0_q + PtrW'(1);
      if (push1) wr_ptr1_d = wr_ptr1_q + PtrW'(1);
      if (pop1)  rd_ptr1_d = rd_ptr1_q + PtrW'(1);
      cnt0_d = cnt0_q + CntW'(push0) - CntW'(pop0);
      cnt1_d = cnt1_q + CntW'(push1) - CntW'(pop1);
    end
  end

  always_comb begin
    we_a_d    = issue_a && !flush_i;
    we_b_d    = issue_b && !flush_i;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    if (we_a_d) begin
      waddr_a_d = h0_addr;
      wdata_a_d = h0_data;
    end
    if (we_b_d) begin
      waddr_b_d = h1_addr;
      wdata_b_d = h1_data;
    end
    busy_d = (cnt0_d != '0) || (cnt1_d != '0) || we_a_d || we_b_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr0_q <= '0;
      rd_ptr0_q <= '0;
      wr_ptr1_q <= '0;
      rd_ptr1_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_a_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      we_b_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr0_q <= wr_ptr0_d;
      rd_ptr0_q <= rd_ptr0_d;
      wr_ptr1_q <= wr_ptr1_d;
      rd_ptr1_q <= rd_ptr1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_a_q    <= we_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      we_b_q    <= we_b_d;
      busy_q    <= busy_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (push0) begin
      addr0_q[wr_ptr0_q] <= src0_addr_i;
      data0_q[wr_ptr0_q] <= src0_data_i;
    end
    if (push1) begin
      addr1_q[wr_ptr1_q] <= src1_addr_i;
      data1_q[wr_ptr1_q] <= src1_data_i;
    end
  end

  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_a_o    = we_a_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign we_b_o    = we_b_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_riscv_nn_wb_arbiter.sv
// Bench for riscv_nn_wb_arbiter: vector table for timing, queue scoreboard for write content.
module tb_riscv_nn_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        src0_valid_i, src1_valid_i;
  logic        src0_ready_o, src1_ready_o;
  logic [4:0]  src0_addr_i, src1_addr_i;
  logic [31:0] src0_data_i, src1_data_i;
  logic [4:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic        we_a_o, we_b_o, busy_o;

  riscv_nn_wb_arbiter #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .src0_valid_i(src0_valid_i),
    .src0_ready_o(src0_ready_o),
    .src0_addr_i(src0_addr_i),
    .src0_data_i(src0_data_i),
    .src1_valid_i(src1_valid_i),
    .src1_ready_o(src1_ready_o),
    .src1_addr_i(src1_addr_i),
    .src1_data_i(src1_data_i),
    .waddr_a_o(waddr_a_o),
    .wdata_a_o(wdata_a_o),
    .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o),
    .wdata_b_o(wdata_b_o),
    .we_b_o(we_b_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ewa2, ewb2, ewa3, ewb3;
  } vec_t;

  wr_t  qa[$];
  wr_t  qb[$];
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; record accepted writes as expected results.
  task automatic tick();
    logic acc0, acc1, fl, rs;
    wr_t  e0, e1;
    acc0 = src0_valid_i && src0_ready_o && !flush_i;
    acc1 = src1_valid_i && src1_ready_o && !flush_i;
    fl   = flush_i;
    rs   = rst_n;
    e0   = '{a: src0_addr_i, d: src0_data_i};
    e1   = '{a: src1_addr_i, d: src1_data_i};
    @(posedge clk);
    if (!rs || fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (acc0 && e0.a != 5'd0) qa.push_back(e0);
      if (acc1 && e1.a != 5'd0) qb.push_back(e1);
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    src0_valid_i = 1'b0;
    src1_valid_i = 1'b0;
    src0_addr_i  = '0;
    src1_addr_i  = '0;
    src0_data_i  = '0;
    src1_data_i  = '0;
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected entry.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (we_a_o) begin
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write_a: got %0h:%0h expected none", waddr_a_o, wdata_a_o);
        end else begin
          e = qa.pop_front();
          check("port_a_write", {27'd0, waddr_a_o, wdata_a_o}, {27'd0, e});
        end
      end
      if (we_b_o) begin
        if (qb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write_b: got %0h:%0h expected none", waddr_b_o, wdata_b_o);
        end else begin
          e = qb.pop_front();
          check("port_b_write", {27'd0, waddr_b_o, wdata_b_o}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    int acc1cnt;
    int cyc;
    logic seen_drop;
    logic rdy;

    vecs[0] = '{1, 5'd3,  32'h11,   1, 5'd7,  32'h22,   1, 1, 0, 0};
    vecs[1] = '{1, 5'd5,  32'hAAAA, 1, 5'd5,  32'hBBBB, 1, 0, 0, 1};
    vecs[2] = '{1, 5'd0,  32'hDEAD, 0, 5'd0,  32'h0,    0, 0, 0, 0};
    vecs[3] = '{1, 5'd0,  32'h1,    1, 5'd0,  32'h2,    0, 0, 0, 0};
    vecs[4] = '{0, 5'd0,  32'h0,    1, 5'd9,  32'h99,   0, 1, 0, 0};
    vecs[5] = '{1, 5'd31, 32'h3131, 0, 5'd0,  32'h0,    1, 0, 0, 0};
    vecs[6] = '{1, 5'd0,  32'h5,    1, 5'd5,  32'h55,   0, 1, 0, 0};
    vecs[7] = '{1, 5'd12, 32'hC0,   1, 5'd13, 32'hD0,   1, 1, 0, 0};

    rst_n   = 1'b0;
    flush_i = 1'b0;
    idle_inputs();
    ticks(2);
    check("reset_outputs", {27'd0, we_a_o, we_b_o, busy_o, waddr_a_o, wdata_a_o},
          64'd0);
    check("reset_outputs_b", {27'd0, waddr_b_o, wdata_b_o}, 64'd0);
    check("reset_ready_low", {62'd0, src0_ready_o, src1_ready_o}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {62'd0, src0_ready_o, src1_ready_o}, 64'd3);
    tick();

    // Single-shot table: write-enable timing at +2 and +3 cycles.
    for (int i = 0; i < 8; i++) begin
      src0_valid_i = vecs[i].v0;
      src0_addr_i  = vecs[i].a0;
      src0_data_i  = vecs[i].d0;
      src1_valid_i = vecs[i].v1;
      src1_addr_i  = vecs[i].a1;
      src1_data_i  = vecs[i].d1;
      tick();
      idle_inputs();
      tick();
      check($sformatf("vec%0d_we_cyc2", i), {62'd0, we_a_o, we_b_o},
            {62'd0, vecs[i].ewa2, vecs[i].ewb2});
      tick();
      check($sformatf("vec%0d_we_cyc3", i), {62'd0, we_a_o, we_b_o},
            {62'd0, vecs[i].ewa3, vecs[i].ewb3});
      ticks(2);
    end
    check("table_idle_busy", {63'd0, busy_o}, 64'd0);

    // R0 drop followed by a real write: one pulse, 3 cycles after first accept.
    src0_valid_i = 1'b1;
    src0_addr_i  = 5'd0;
    src0_data_i  = 32'hDEAD;
    tick();
    src0_addr_i  = 5'd4;
    src0_data_i  = 32'h1;
    tick();
    idle_inputs();
    check("r0_no_we_cyc2", {63'd0, we_a_o}, 64'd0);
    tick();
    check("r0_we_cyc3", {26'd0, we_a_o, waddr_a_o, wdata_a_o}, {26'd0, 1'b1, 5'd4, 32'h1});
    tick();
    check("r0_we_single", {63'd0, we_a_o}, 64'd0);
    ticks(2);

    // Backpressure: src0 stream to the same address stalls source 1.
    acc1cnt   = 0;
    cyc       = 0;
    seen_drop = 1'b0;
    while (acc1cnt < 4 && cyc < 60) begin
      src0_valid_i = (cyc < 8);
      src0_addr_i  = 5'd6;
      src0_data_i  = 32'h600 + 32'(cyc);
      src1_valid_i = 1'b1;
      src1_addr_i  = 5'd6;
      src1_data_i  = 32'h100 + 32'(acc1cnt);
      rdy = src1_ready_o;
      tick();
      if (rdy) acc1cnt++;
      if (acc1cnt == 2 && !seen_drop) begin
        check("bp_ready_drops", {63'd0, src1_ready_o}, 64'd0);
        seen_drop = 1'b1;
      end
      cyc++;
    end
    idle_inputs();
    check("bp_all_accepted", 64'(acc1cnt), 64'd4);
    ticks(8);
    check("bp_drained_a", 64'(qa.size()), 64'd0);
    check("bp_drained_b", 64'(qb.size()), 64'd0);

    // Flush with pending entries; the request presented during flush is dropped.
    for (int i = 0; i < 2; i++) begin
      src0_valid_i = 1'b1;
      src0_addr_i  = 5'd8;
      src0_data_i  = 32'hA0 + 32'(i);
      src1_valid_i = 1'b1;
      src1_addr_i  = 5'd8;
      src1_data_i  = 32'hB0 + 32'(i);
      tick();
    end
    flush_i     = 1'b1;
    src0_data_i = 32'hF0;
    src1_data_i = 32'hF1;
    tick();
    flush_i = 1'b0;
    idle_inputs();
    check("flush_outputs", {61'd0, we_a_o, we_b_o, busy_o}, 64'd0);
    check("flush_ready", {62'd0, src0_ready_o, src1_ready_o}, 64'd3);
    ticks(4);
    check("flush_idle_busy", {63'd0, busy_o}, 64'd0);

    // Reset mid-operation with source 1 backed up behind collisions.
    for (int i = 0; i < 3; i++) begin
      src0_valid_i = 1'b1;
      src0_addr_i  = 5'd10;
      src0_data_i  = 32'hC0 + 32'(i);
      src1_valid_i = 1'b1;
      src1_addr_i  = 5'd10;
      src1_data_i  = 32'hD0 + 32'(i);
      tick();
    end
    check("pre_reset_src1_full", {63'd0, src1_ready_o}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_ready_low", {62'd0, src0_ready_o, src1_ready_o}, 64'd0);
    tick();
    check("rst_outputs", {27'd0, we_a_o, we_b_o, busy_o, waddr_a_o, wdata_a_o}, 64'd0);
    check("rst_outputs_b", {27'd0, waddr_b_o, wdata_b_o}, 64'd0);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    check("rst_release_ready", {62'd0, src0_ready_o, src1_ready_o}, 64'd3);
    ticks(6);
    check("post_reset_busy", {63'd0, busy_o}, 64'd0);
    check("final_queue_a", 64'(qa.size()), 64'd0);
    check("final_queue_b", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
